apb_rmw_master: RTL and testbench



---
 rtl/apb_rmw_master.sv | 184 ++++++++++++++++++
 tb/tb_apb_rmw_master.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_rmw_master.sv
// APB requester running read, write and read-modify-write-add commands from a
// valid/ready command port, with slave-error capture and a wait-state timeout.
module apb_rmw_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          psel,
  output logic          penable,
  output logic [AW-1:0] paddr,
  output logic          pwrite,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_WSETUP  = 3'd3;
  localparam logic [2:0] S_WACCESS = 3'd4;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;

  // Last counter value before the abort; unused when TIMEOUT is 0.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [2:0]    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] addend_q, addend_d;
  logic [DW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          ready_q, ready_d;
  logic          go_idle_s;
  logic          timeout_hit_s;

  assign timeout_hit_s = (TIMEOUT != 0) && !pready && (cnt_q == TO_LAST);

  // Next-state and datapath decode for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addend_d    = addend_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    go_idle_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d  = S_SETUP;
          op_d     = cmd_op;
          addend_d = cmd_wdata;
          paddr_d  = cmd_addr;
          pwrite_d = (cmd_op == OP_WRITE);
          pwdata_d = (cmd_op == OP_WRITE) ? cmd_wdata : '0;
          cnt_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP:  state_d = S_ACCESS;
      S_WSETUP: state_d = S_WACCESS;
      S_ACCESS, S_WACCESS: begin
        if (pready) begin
          if (pslverr) begin
            go_idle_s = 1'b1;
            rsp_err_d = 1'b1;
          end else if ((state_q == S_ACCESS) && (op_q == OP_RMW)) begin
            state_d  = S_WSETUP;
            rd_d     = prdata;
            pwrite_d = 1'b1;
            pwdata_d = prdata + addend_q;
            cnt_d    = '0;
          end else begin
            go_idle_s = 1'b1;
            if (state_q == S_WACCESS) begin
              rsp_rdata_d = rd_q;
            end else if (op_q == OP_WRITE) begin
              rsp_rdata_d = '0;
            end else begin
              rsp_rdata_d = prdata;
            end
          end
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (timeout_hit_s) begin
            go_idle_s = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            go_idle_s = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Completion or abort: bus returns to its quiet values and the response pulses.
    if (go_idle_s) begin
      state_d     = S_IDLE;
      paddr_d     = '0;
      pwrite_d    = 1'b0;
      pwdata_d    = '0;
      rsp_valid_d = 1'b1;
    end else begin
      rsp_valid_d = 1'b0;
    end
    psel_d    = (state_d != S_IDLE);
    penable_d = (state_d == S_ACCESS) || (state_d == S_WACCESS);
    ready_d   = (state_d == S_IDLE);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      addend_q    <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addend_q    <= addend_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ready_q     <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_rmw_master.sv
// Directed bench for apb_rmw_master: a table of commands with hand-computed
// responses, a reactive APB slave, and hand-written reset sequences.
module tb_apb_rmw_master;

  logic        pclk;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int errors = 0;
  int checks = 0;

  apb_rmw_master #(.AW(32), .DW(32), .TIMEOUT(4), .CW(8)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          w0;
    logic        e0;
    int          w1;
    logic        e1;
    logic [31:0] wp;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    int          acc;
    int          setups;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rd,
                              input int w0, input logic e0, input int w1, input logic e1,
                              input logic [31:0] wp, input logic [31:0] exp_rdata,
                              input logic exp_err, input int lat, input int acc,
                              input int setups);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.w0 = w0; v.e0 = e0; v.w1 = w1; v.e1 = e1; v.wp = wp;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.lat = lat; v.acc = acc; v.setups = setups;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one command at the current negedge and act as the APB slave until the response.
  task automatic run(input int idx, input vec_t v);
    int   cyc = 0;
    int   acc = 0;
    int   setups = 0;
    int   ph_wait = 0;
    bit   done = 1'b0;
    bit   wr_ph;
    logic [31:0] exp_pwd;
    logic exp_pw;
    chk($sformatf("v%0d cmd_ready", idx), 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr; cmd_wdata = v.wdata;
    @(negedge pclk);
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    cyc = 1;
    while (!done && cyc < 40) begin
      pready = 1'b0; pslverr = 1'b1; prdata = 32'hBAD0_BAD0;
      if (rsp_valid) begin
        chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.lat));
        chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
        chk($sformatf("v%0d access_cycles", idx), 32'(acc), 32'(v.acc));
        chk($sformatf("v%0d setups", idx), 32'(setups), 32'(v.setups));
        chk($sformatf("v%0d idle_bus", idx),
            {27'd0, psel, penable, pwrite, |paddr, |pwdata}, 32'd0);
        done = 1'b1;
      end else begin
        if (psel) begin
          if (!penable) begin
            setups++;
            ph_wait = 0;
          end else begin
            acc++;
          end
          wr_ph   = (setups == 2);
          exp_pw  = (v.op == 2'b01) || wr_ph;
          exp_pwd = wr_ph ? v.wp : ((v.op == 2'b01) ? v.wdata : 32'h0);
          chk($sformatf("v%0d paddr", idx), paddr, v.addr);
          chk($sformatf("v%0d pwrite", idx), 32'(pwrite), 32'(exp_pw));
          chk($sformatf("v%0d pwdata", idx), pwdata, exp_pwd);
          if (penable) begin
            if (ph_wait == (wr_ph ? v.w1 : v.w0)) begin
              pready  = 1'b1;
              pslverr = wr_ph ? v.e1 : v.e0;
              prdata  = wr_ph ? 32'h0BAD_0BAD : v.rd;
            end else begin
              pready = 1'b0;
            end
            ph_wait++;
          end
        end
        @(negedge pclk);
        cyc++;
      end
    end
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    if (!done) chk($sformatf("v%0d rsp_wait_expired", idx), 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;

    //          op     addr          wdata         rd            w0 e0 w1 e1 wp            rdata         err lat acc set
    vecs[0] = mk(2'd0, 32'h0000_A000, 32'h0,        32'h0000_0005, 0, 0, 0, 0, 32'h0,        32'h0000_0005, 0,  3, 1, 1);
    vecs[1] = mk(2'd1, 32'h0000_0010, 32'h1234_5678, 32'h0,       3, 0, 0, 0, 32'h0,        32'h0,         0,  6, 4, 1);
    vecs[2] = mk(2'd2, 32'h0000_A000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h0,      32'hFFFF_FFFF, 0,  5, 2, 2);
    vecs[3] = mk(2'd2, 32'h0000_0020, 32'h0000_0010, 32'h0000_07F0, 0, 1, 0, 0, 32'h0,      32'h0,         1,  3, 1, 1);
    vecs[4] = mk(2'd0, 32'h0000_0030, 32'h0,        32'h1111_1111, 99, 0, 0, 0, 32'h0,       32'h0,         1,  6, 4, 1);
    vecs[5] = mk(2'd0, 32'h0000_0044, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0,        32'hDEAD_BEEF, 0,  3, 1, 1);
    vecs[6] = mk(2'd2, 32'h0000_0100, 32'h0000_0005, 32'h0000_0010, 1, 0, 2, 0, 32'h0000_0015, 32'h0000_0010, 0, 8, 5, 2);
    vecs[7] = mk(2'd3, 32'h0000_0008, 32'h0000_0099, 32'h0000_0077, 0, 0, 0, 0, 32'h0,      32'h0000_0077, 0,  3, 1, 1);
    vecs[8] = mk(2'd1, 32'h0000_0050, 32'h0000_00AB, 32'h0,       0, 1, 0, 0, 32'h0,        32'h0,         1,  3, 1, 1);
    vecs[9] = mk(2'd2, 32'h0000_0060, 32'h0000_0002, 32'h0000_0040, 3, 0, 99, 0, 32'h0000_0042, 32'h0,     1, 11, 8, 2);

    repeat (3) @(negedge pclk);
    chk("reset outputs",
        {23'd0, cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite, |paddr, |pwdata, |rsp_rdata},
        32'd0);
    preset = 1'b0;
    @(negedge pclk);
    chk("ready after reset", 32'(cmd_ready), 32'd1);
    chk("psel after reset", 32'(psel), 32'd0);

    // Back-to-back: each command is issued in the previous response cycle.
    for (int i = 0; i < 10; i++) run(i, vecs[i]);
    @(negedge pclk);
    chk("rsp_valid one cycle", 32'(rsp_valid), 32'd0);

    // Reset during the write phase of an RMW.
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 32'h0000_0200; cmd_wdata = 32'h0000_0003;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("rst seq access", {30'd0, psel, penable}, 32'd3);
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h0000_0001;
    @(negedge pclk);
    pready = 1'b0; prdata = 32'h0;
    @(negedge pclk);
    chk("rst seq waccess", {29'd0, psel, penable, pwrite}, 32'd7);
    chk("rst seq wdata", pwdata, 32'h0000_0004);
    preset = 1'b1;
    @(negedge pclk);
    chk("mid-reset outputs",
        {23'd0, cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite, |paddr, |pwdata, |rsp_rdata},
        32'd0);
    preset = 1'b0;
    @(negedge pclk);
    chk("ready after mid-reset", 32'(cmd_ready), 32'd1);
    chk("no rsp for aborted", 32'(rsp_valid), 32'd0);
    run(10, vecs[5]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
